// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg: shared definitions for the GPIO pad sense slice.
//   - pad drive mode encodings ({mode1, mode0})
//   - debounce FSM state type
//   - decoded pad configuration struct and its decode function
package gpio_pad_pkg;

    localparam logic [1:0] MODE_INVALID = 2'b00;
    localparam logic [1:0] MODE_INPUT   = 2'b01;
    localparam logic [1:0] MODE_OUTPUT  = 2'b10;
    localparam logic [1:0] MODE_PULL    = 2'b11;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_QUALIFY = 1'b1
    } db_state_t;

    typedef struct packed {
        logic outenb;
        logic pu;
        logic pd;
    } pad_cfg_t;

    // Invalid mode keeps the previous readback so the core never sees a
    // transient bogus pull/drive configuration.
    function automatic pad_cfg_t decode_mode(input logic [1:0] mode,
                                             input logic       out_val,
                                             input pad_cfg_t   prev);
        pad_cfg_t cfg;
        cfg = prev;
        case (mode)
            MODE_OUTPUT: cfg = '{outenb: 1'b0, pu: 1'b0,    pd: 1'b0};
            MODE_INPUT:  cfg = '{outenb: 1'b1, pu: 1'b0,    pd: 1'b0};
            MODE_PULL:   cfg = '{outenb: 1'b1, pu: out_val, pd: ~out_val};
            default:     cfg = prev;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/gpio_pad_sense_if.sv
// gpio_pad_sense_if: pad-ring side signal bundle of one GPIO pad.
//   gpio_in_pad      pad input buffer output (asynchronous)
//   gpio_inenb_pad   input buffer disable (1 = off)
//   gpio_out_pad     value driven to the pad / pull direction in pull mode
//   gpio_outenb_pad  output driver disable
//   gpio_mode1_pad, gpio_mode0_pad  pad drive mode
// master = pad ring (drives the bundle), slave = gpio_pad_sense (observes it).
interface gpio_pad_sense_if;
    logic gpio_in_pad;
    logic gpio_inenb_pad;
    logic gpio_out_pad;
    logic gpio_outenb_pad;
    logic gpio_mode1_pad;
    logic gpio_mode0_pad;

    modport master (
        output gpio_in_pad, gpio_inenb_pad, gpio_out_pad,
               gpio_outenb_pad, gpio_mode1_pad, gpio_mode0_pad
    );

    modport slave (
        input  gpio_in_pad, gpio_inenb_pad, gpio_out_pad,
               gpio_outenb_pad, gpio_mode1_pad, gpio_mode0_pad
    );
endinterface

// File: rtl/gpio_debounce.sv
// gpio_debounce: two-flop synchronizer followed by a debounce FSM.
//   clk, resetn  core clock, asynchronous active-low reset
//   din          asynchronous input
//   dout         debounced input; changes only after the synchronized value
//                differs from it for DEBOUNCE_CYC consecutive cycles
//   dbg_state    current FSM state (STABLE / QUALIFY)
module gpio_debounce
    import gpio_pad_pkg::*;
#(
    parameter int DEBOUNCE_W   = 4,
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      din,
    output logic      dout,
    output db_state_t dbg_state
);

    localparam logic [0:0] ST_STABLE  = DB_STABLE;
    localparam logic [0:0] ST_QUALIFY = DB_QUALIFY;
    // Terminal count; DEBOUNCE_CYC <= 2^DEBOUNCE_W so this always fits.
    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYC - 1);

    logic                  sync1;
    logic                  sync2;
    logic [0:0]            state;
    logic [DEBOUNCE_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // cnt counts consecutive cycles where sync2 disagrees with dout; it only
    // increments below CNT_LAST, so it cannot wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_STABLE;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            case (state)
                ST_STABLE: begin
                    if (sync2 != dout) begin
                        if (DEBOUNCE_CYC == 1) begin
                            dout <= sync2;
                        end else begin
                            cnt   <= DEBOUNCE_W'(1);
                            state <= ST_QUALIFY;
                        end
                    end
                end
                ST_QUALIFY: begin
                    if (sync2 == dout) begin
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end else if (cnt == CNT_LAST) begin
                        dout  <= sync2;
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end else begin
                        cnt <= cnt + DEBOUNCE_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_STABLE;
                end
            endcase
        end
    end

    assign dbg_state = db_state_t'(state);

endmodule

// File: rtl/gpio_pad_sense.sv
// gpio_pad_sense: per-pad GPIO sense slice.
//   clk, resetn     core clock, asynchronous active-low reset
//   pad             pad-ring bundle (slave modport)
//   irq_en[1:0]     bit0 rising-edge irq enable, bit1 falling-edge irq enable
//   irq_clr         single-cycle clear of irq
//   gpio_in         debounced input
//   gpio_rise/fall  one-cycle pulses the cycle after gpio_in changes
//   irq             sticky interrupt (set has priority over clear)
//   gpio_outenb, gpio_pu, gpio_pd  registered mode decode
//   cfg_err         illegal pad configuration, one cycle after the inputs
//   dbg_state       debounce FSM state
module gpio_pad_sense
    import gpio_pad_pkg::*;
#(
    parameter int DEBOUNCE_W   = 4,
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    gpio_pad_sense_if.slave         pad,
    input  logic [1:0]              irq_en,
    input  logic                    irq_clr,
    output logic                    gpio_in,
    output logic                    gpio_rise,
    output logic                    gpio_fall,
    output logic                    irq,
    output logic                    gpio_outenb,
    output logic                    gpio_pu,
    output logic                    gpio_pd,
    output logic                    cfg_err,
    output db_state_t               dbg_state
);

    logic       din;
    logic       gpio_in_d;
    logic       irq_set;
    logic [1:0] mode;
    pad_cfg_t   cfg_q;

    // A disabled input buffer reads as 0 and goes through the same debounce.
    assign din  = pad.gpio_in_pad & ~pad.gpio_inenb_pad;
    assign mode = {pad.gpio_mode1_pad, pad.gpio_mode0_pad};

    gpio_debounce #(
        .DEBOUNCE_W   (DEBOUNCE_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk       (clk),
        .resetn    (resetn),
        .din       (din),
        .dout      (gpio_in),
        .dbg_state (dbg_state)
    );

    assign irq_set = (gpio_rise & irq_en[0]) | (gpio_fall & irq_en[1]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gpio_in_d <= 1'b0;
            gpio_rise <= 1'b0;
            gpio_fall <= 1'b0;
            irq       <= 1'b0;
        end else begin
            gpio_in_d <= gpio_in;
            gpio_rise <= gpio_in & ~gpio_in_d;
            gpio_fall <= ~gpio_in & gpio_in_d;
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_q   <= '{outenb: 1'b1, pu: 1'b0, pd: 1'b0};
            cfg_err <= 1'b0;
        end else begin
            cfg_q   <= decode_mode(mode, pad.gpio_out_pad, cfg_q);
            cfg_err <= (mode == MODE_INVALID)
                     | (pad.gpio_outenb_pad != ~pad.gpio_mode1_pad)
                     | (pad.gpio_inenb_pad  != ~pad.gpio_mode0_pad);
        end
    end

    assign gpio_outenb = cfg_q.outenb;
    assign gpio_pu     = cfg_q.pu;
    assign gpio_pd     = cfg_q.pd;

endmodule

// File: tb/tb_gpio_pad_sense.sv
// tb_gpio_pad_sense: directed test-plan phases followed by random pad
// activity. Every cycle the driver pushes the outputs predicted by a
// behavioural model into exp_q; the monitor pops one entry after each rising
// edge and compares it to the DUT.
module tb_gpio_pad_sense;
    import gpio_pad_pkg::*;

    localparam int CYC = 8;
    localparam int W   = 9;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] irq_en;
    logic       irq_clr;
    logic       gpio_in, gpio_rise, gpio_fall, irq;
    logic       gpio_outenb, gpio_pu, gpio_pd, cfg_err;
    db_state_t  dbg_state;

    gpio_pad_sense_if pad_if ();

    gpio_pad_sense #(.DEBOUNCE_W(4), .DEBOUNCE_CYC(CYC)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pad         (pad_if.slave),
        .irq_en      (irq_en),
        .irq_clr     (irq_clr),
        .gpio_in     (gpio_in),
        .gpio_rise   (gpio_rise),
        .gpio_fall   (gpio_fall),
        .irq         (irq),
        .gpio_outenb (gpio_outenb),
        .gpio_pu     (gpio_pu),
        .gpio_pd     (gpio_pd),
        .cfg_err     (cfg_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int tests  = 0;
    int failed = 0;
    int cycle  = 0;

    // ---------------- reference model ----------------
    // Pad value seen by the debouncer is the masked pad delayed two cycles.
    // gpio_in takes the delayed value once it has disagreed with gpio_in for
    // CYC consecutive cycles (run = length of the current disagreement).
    logic m_d1, m_d2;
    logic m_gin, m_gin_last, m_rise, m_fall, m_irq;
    logic m_oe, m_pu, m_pd, m_err;
    int   m_run;

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0; m_gin = 0; m_gin_last = 0;
        m_rise = 0; m_fall = 0; m_irq = 0;
        m_oe = 1; m_pu = 0; m_pd = 0; m_err = 0; m_run = 0;
    endtask

    task automatic model_step();
        logic       nxt_gin, nxt_irq;
        logic [1:0] md;
        if (!resetn) begin
            model_reset();
        end else begin
            nxt_gin = m_gin;
            if (m_d2 != m_gin) begin
                m_run = m_run + 1;
                if (m_run == CYC) begin
                    nxt_gin = m_d2;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            if ((m_rise && irq_en[0]) || (m_fall && irq_en[1])) nxt_irq = 1;
            else if (irq_clr)                                  nxt_irq = 0;
            else                                               nxt_irq = m_irq;
            m_rise     = (m_gin == 1) && (m_gin_last == 0);
            m_fall     = (m_gin == 0) && (m_gin_last == 1);
            m_gin_last = m_gin;
            m_gin      = nxt_gin;
            m_irq      = nxt_irq;
            md = {pad_if.gpio_mode1_pad, pad_if.gpio_mode0_pad};
            if (md == 2'b10) begin m_oe = 0; m_pu = 0; m_pd = 0; end
            if (md == 2'b01) begin m_oe = 1; m_pu = 0; m_pd = 0; end
            if (md == 2'b11) begin m_oe = 1; m_pu = pad_if.gpio_out_pad; m_pd = !pad_if.gpio_out_pad; end
            m_err = (md == 2'b00)
                 || (pad_if.gpio_outenb_pad == pad_if.gpio_mode1_pad)
                 || (pad_if.gpio_inenb_pad  == pad_if.gpio_mode0_pad);
            m_d2 = m_d1;
            m_d1 = pad_if.gpio_in_pad & ~pad_if.gpio_inenb_pad;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are changed at the falling edge; step() predicts the state after
    // the next rising edge and then waits one full cycle.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            exp_q.push_back({m_gin, m_rise, m_fall, m_irq, m_oe, m_pu, m_pd,
                             m_err, (m_run != 0)});
            @(negedge clk);
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        pad_if.gpio_mode1_pad  = m[1];
        pad_if.gpio_mode0_pad  = m[0];
        pad_if.gpio_outenb_pad = ~m[1];
        pad_if.gpio_inenb_pad  = ~m[0];
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [W-1:0] exp_v, act_v;
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {gpio_in, gpio_rise, gpio_fall, irq, gpio_outenb, gpio_pu,
                     gpio_pd, cfg_err, (dbg_state == DB_QUALIFY)};
            tests++;
            if (act_v !== exp_v) begin
                failed++;
                $display("FAIL outputs cycle %0d {in,rise,fall,irq,oe,pu,pd,err,qual}: got %b expected %b",
                         cycle, act_v, exp_v);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int hold;
        resetn  = 0;
        irq_en  = 2'b00;
        irq_clr = 0;
        pad_if.gpio_in_pad  = 1;
        pad_if.gpio_out_pad = 1;
        set_mode(2'b11);
        model_reset();
        @(negedge clk);

        // reset values with pad=1, then requalify after release
        step(4);
        resetn = 1;
        step(14);

        // glitch rejection
        pad_if.gpio_in_pad = 0; step(14);
        pad_if.gpio_in_pad = 1; step(5);
        pad_if.gpio_in_pad = 0; step(14);

        // rising edge with irq, then falling edge not enabled
        irq_en = 2'b01;
        pad_if.gpio_in_pad = 1; step(14);
        pad_if.gpio_in_pad = 0; step(14);

        // set/clear collision on an enabled falling edge (irq still pending)
        irq_en = 2'b10;
        pad_if.gpio_in_pad = 1; step(14);
        pad_if.gpio_in_pad = 0;
        for (int i = 0; i < 20; i++) begin
            irq_clr = m_fall;
            step(1);
            if (irq_clr) break;
        end
        irq_clr = 1; step(1);
        irq_clr = 0; step(2);

        // config decode
        pad_if.gpio_out_pad = 1; set_mode(2'b11); step(2);
        pad_if.gpio_out_pad = 0; step(2);
        set_mode(2'b10); step(2);
        set_mode(2'b00); step(2);
        set_mode(2'b11); step(1);
        set_mode(2'b00); pad_if.gpio_out_pad = 1; step(2);
        set_mode(2'b01); pad_if.gpio_outenb_pad = 0; step(2);

        // input disable mid-operation
        set_mode(2'b01);
        pad_if.gpio_in_pad = 1; step(14);
        pad_if.gpio_inenb_pad = 1; step(14);
        pad_if.gpio_inenb_pad = 0; step(14);

        // reset in the middle of qualification (cnt reaches 4)
        pad_if.gpio_in_pad = 0; step(14);
        pad_if.gpio_in_pad = 1; step(6);
        resetn = 0; step(1);
        resetn = 1; step(14);

        // random activity
        for (int seg = 0; seg < 80; seg++) begin
            pad_if.gpio_in_pad  = 1'($urandom_range(0, 1));
            pad_if.gpio_out_pad = 1'($urandom_range(0, 1));
            irq_en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) set_mode(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) pad_if.gpio_outenb_pad = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) pad_if.gpio_inenb_pad  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 14);
            for (int c = 0; c < hold; c++) begin
                irq_clr = ($urandom_range(0, 9) == 0);
                resetn  = ($urandom_range(0, 199) != 0);
                step(1);
            end
            resetn = 1;
        end
        irq_clr = 0;

        // drain: everything pushed must have been compared
        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/gpio_pad_sense.md
# gpio_pad_sense

Pad-side companion to the GPIO signal converter: it takes the asynchronous pad input and the pad control signals (output, output enable, input enable, mode) and returns the standard GPIO view to the core. The core sees a synchronized, debounced input, edge events and a sticky interrupt, plus a decoded readback of the pad configuration (outenb, pullup, pulldown). It is bit-sliced, with one instance per GPIO pad, and sits between the pad ring and the housekeeping/GPIO register logic.

## Interface
Parameters:
- `DEBOUNCE_W`, default 4: width of the debounce counter.
- `DEBOUNCE_CYC`, default 8: stable cycles required to accept an input change. Legal range is 1 to 2^DEBOUNCE_W.

Ports:
- `clk` input 1: core clock; all state is on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `gpio_in_pad` input 1: pad input buffer output, asynchronous to `clk`.
- `gpio_inenb_pad` input 1: pad input disable; 1 means the input buffer is off.
- `gpio_out_pad` input 1: value driven to the pad; also selects pull direction in pull mode.
- `gpio_outenb_pad` input 1: pad output disable (readback only, for error check).
- `gpio_mode1_pad`, `gpio_mode0_pad` input 1 each: pad drive mode.
- `irq_en` input 2: bit0 enables the rising-edge interrupt, bit1 enables the falling-edge interrupt.
- `irq_clr` input 1: single-cycle clear of `irq`.
- `gpio_in` output 1: debounced input.
- `gpio_rise`, `gpio_fall` output 1 each: one-cycle edge pulses of `gpio_in`.
- `irq` output 1: sticky interrupt.
- `gpio_outenb` output 1: decoded output disable.
- `gpio_pu`, `gpio_pd` output 1 each: decoded pullup and pulldown.
- `cfg_err` output 1: illegal pad configuration.

## Operation
- **Synchronizer:** two flops on `gpio_in_pad & ~gpio_inenb_pad`. With input disabled, the stage input is forced to 0.
- **Debounce FSM**, states STABLE and QUALIFY, with counter `cnt` (`DEBOUNCE_W` bits):
  - STABLE: if the sync output differs from `gpio_in`, set `cnt` to 1 and go to QUALIFY. If `DEBOUNCE_CYC`=1, instead update `gpio_in` directly and stay in STABLE.
  - QUALIFY: if the sync output equals `gpio_in` (glitch), set `cnt` to 0 and return to STABLE.
  - QUALIFY: else if `cnt`==`DEBOUNCE_CYC`-1, set `gpio_in` to the sync output, set `cnt` to 0 and go to STABLE.
  - QUALIFY: otherwise increment `cnt`. The counter never wraps.
- **Edges:**
  - `gpio_rise`=1 for exactly the cycle after `gpio_in` goes 0→1.
  - `gpio_fall`=1 for exactly the cycle after `gpio_in` goes 1→0.
- **Interrupt:** `irq` sets on `(gpio_rise & irq_en[0]) | (gpio_fall & irq_en[1])`.
  - `irq` clears on `irq_clr`.
  - Set and clear in the same cycle: set wins.
  - Changing `irq_en` does not clear a pending `irq`.
- **Config decode**, registered every cycle from `{mode1, mode0}`:
  - 2'b10: output; `gpio_outenb`=0, `gpio_pu`=0, `gpio_pd`=0.
  - 2'b01: input, no pull; `gpio_outenb`=1, `gpio_pu`=0, `gpio_pd`=0.
  - 2'b11: input with pull; `gpio_outenb`=1, `gpio_pu`=`gpio_out_pad`, `gpio_pd`=~`gpio_out_pad`.
  - 2'b00: invalid; `cfg_err`=1, and the other decode outputs hold their previous value.
- **`cfg_err` conditions.** `cfg_err` is also 1 when either of the following holds:
  - `gpio_outenb_pad` ≠ ~`mode1`.
  - `gpio_inenb_pad` ≠ ~`mode0`.
  
  `cfg_err` is not sticky; it reflects the current cycle's inputs one cycle later.

## Timing
- **Reset values:**
  - `gpio_in`=0, `gpio_rise`=0, `gpio_fall`=0, `irq`=0, `cfg_err`=0, `gpio_pu`=0, `gpio_pd`=0.
  - `gpio_outenb`=1 (safe input).
  - FSM in STABLE, `cnt`=0, sync flops 0.
- **Input latency:** a pad change held stable reaches `gpio_in` 2 + `DEBOUNCE_CYC` cycles after the first sampling edge.
- **Edge and interrupt latency:**
  - Edge pulse appears 1 cycle after `gpio_in` changes.
  - `irq` rises the cycle after the pulse.
- **Config readback:** 1-cycle latency.
- **Glitches:** a pulse shorter than `DEBOUNCE_CYC` cycles after the synchronizer produces no `gpio_in` change and no event.
- **Reset mid-QUALIFY:** the pending change is discarded; after reset release, a pad held at 1 is re-qualified from scratch.
- **Input disable mid-operation:** this acts as a pad transition to 0 and obeys the same debounce.

## Structure
- **Package `gpio_pad_pkg`:**
  - Mode constants `MODE_INVALID`=2'b00, `MODE_INPUT`=2'b01, `MODE_OUTPUT`=2'b10, `MODE_PULL`=2'b11.
  - Debounce state enum (STABLE, QUALIFY).
- **Sub-module `gpio_debounce`:**
  - Contains the synchronizer, FSM and counter.
  - Ports: `clk`, `resetn`, `din`, `dout`.
  - Parameters: `DEBOUNCE_W`, `DEBOUNCE_CYC`.
- **Top level:** edge detect, interrupt and config decode.

## Test plan
- **Reset values:** hold `resetn`=0 with pad=1 and mode=2'b11 → all outputs at their reset values (`gpio_outenb`=1). After release, `gpio_in`=1 at cycle 2+8.
- **Glitch rejection:** pad 0→1 for 5 cycles then back to 0 (`DEBOUNCE_CYC`=8) → `gpio_in` stays 0 and there is no `gpio_rise`.
- **Rising edge and interrupt:** pad 0→1 held with `irq_en`=2'b01 → `gpio_rise` pulses once at cycle 11 and `irq`=1 at cycle 12. A falling edge then produces `gpio_fall` but leaves `irq` unchanged.
- **Set/clear collision:** assert `irq_clr` in the same cycle as an enabled `gpio_fall` with `irq_en`=2'b10 → `irq` stays 1. `irq_clr` on the next cycle → `irq`=0.
- **Config decode:**
  - mode=2'b11 with `gpio_out_pad`=1 → `gpio_pu`=1, `gpio_pd`=0.
  - mode=2'b11 with `gpio_out_pad`=0 → `gpio_pu`=0, `gpio_pd`=1.
  - mode=2'b10 → `gpio_outenb`=0.
  - mode=2'b00 → `cfg_err`=1 and the other decode outputs are held.
- **Input disable and reset mid-qualify:**
  - `gpio_inenb_pad`=1 with pad=1 and `gpio_in`=1 → `gpio_in`=0 after 2+8 cycles.
  - `resetn` pulsed at QUALIFY `cnt`=4 → `gpio_in`=0 and requalification restarts.
